// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-to-memory slave front end.
// Frame layout: [FRAME_W-1:FRAME_W-2] command, [DATA_W-1:0] payload.
package spi_pkg;

   localparam int DATA_W  = 8;
   localparam int FRAME_W = DATA_W + 2;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } spi_state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, serial-out register returning memory read data MSB first.
// o_serial carries the current bit while busy and is 0 otherwise.
module spi_tx_shifter #(
   parameter int W = spi_pkg::DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   output logic         o_serial,
   output logic         o_busy,
   output logic         o_done
);

   localparam int CntW = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0]    r_shReg;
   logic [CntW-1:0] r_cnt;
   logic            r_busy;
   logic            r_done;

   // r_cnt holds how many bits remain after the one currently on o_serial
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shReg <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_clear) begin
         r_shReg <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_load) begin
         r_shReg <= i_data;
         r_cnt   <= CntW'(W - 1);
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else if (r_busy) begin
         if (r_cnt == '0) begin
            r_shReg <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end else begin
            r_shReg <= {r_shReg[W-2:0], 1'b0};
            r_cnt   <= r_cnt - CntW'(1);
         end
      end
   end

   assign o_serial = r_busy & r_shReg[W-1];
   assign o_busy   = r_busy;
   assign o_done   = r_done;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into command words and
// serialises one memory read byte back on MISO after a read-data frame.
module spi_slave_if #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MOSI,
   input  logic              SS_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid
);

   import spi_pkg::*;

   localparam int FW   = DATA_W + 2;
   localparam int CntW = $clog2(FW + 1);

   spi_state_e      r_state;
   spi_state_e      w_nextState;
   logic [FW-1:0]   r_shift;
   logic [CntW-1:0] r_bitCnt;
   logic            r_rdAddrSeen;

   logic            w_frameDone;
   logic            w_lastBit;
   logic            w_clearTx;
   logic            w_txLoad;
   logic            w_txBusy;
   logic            w_txDone;
   logic            w_txSerial;

   assign w_frameDone = (r_bitCnt == CntW'(FW));
   assign w_lastBit   = (r_bitCnt == CntW'(FW - 1));
   assign w_clearTx   = (r_state == IDLE) || SS_n;

   // tx_valid only counts once, in the wait phase after a read-data frame
   assign w_txLoad = (r_state == READ_DATA) && w_frameDone && !SS_n &&
                     tx_valid && !w_txBusy && !w_txDone;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (!SS_n) begin
               w_nextState = CHK_CMD;
            end
         end
         CHK_CMD: begin
            if (SS_n) begin
               w_nextState = IDLE;
            end else if (MOSI == CMD_RD_ADDR[1]) begin
               w_nextState = r_rdAddrSeen ? READ_DATA : READ_ADD;
            end else begin
               w_nextState = WRITE;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Receive path; the command bits are forwarded exactly as shifted in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift      <= '0;
         r_bitCnt     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         r_rdAddrSeen <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if ((r_state == IDLE) || SS_n) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
         end else if (!w_frameDone) begin
            r_shift  <= {r_shift[FW-2:0], MOSI};
            r_bitCnt <= r_bitCnt + CntW'(1);
            if (w_lastBit) begin
               rx_data  <= {r_shift[FW-2:0], MOSI};
               rx_valid <= 1'b1;
               if (r_state == READ_ADD) begin
                  r_rdAddrSeen <= 1'b1;
               end else if (r_state == READ_DATA) begin
                  r_rdAddrSeen <= 1'b0;
               end
            end
         end
      end
   end

   spi_tx_shifter #(
      .W (DATA_W)
   ) u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_clearTx),
      .i_load   (w_txLoad),
      .i_data   (tx_data),
      .o_serial (w_txSerial),
      .o_busy   (w_txBusy),
      .o_done   (w_txDone)
   );

   assign MISO = w_txSerial;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if: write, read-address,
// read-data, abort, spurious tx_valid and mid-frame reset.
module tb_spi_slave_if;

   import spi_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       MOSI;
   logic       SS_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;

   int total = 0;
   int bad   = 0;

   spi_slave_if #(
      .DATA_W (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .MOSI     (MOSI),
      .SS_n     (SS_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drops SS_n, waits for E0, then shifts nBits frame bits starting at bit 9
   task automatic applyStimulus(input logic [9:0] frame, input int nBits);
      SS_n = 1'b0;
      tick();
      for (int b = 9; b > 9 - nBits; b--) begin
         MOSI = frame[b];
         tick();
         checkOutput("miso_during_frame", 32'(MISO), 32'd0);
         if (b != 0) begin
            checkOutput("no_early_rx_valid", 32'(rx_valid), 32'd0);
         end
      end
      MOSI = 1'b0;
   endtask

   logic [7:0] expByte;

   initial begin
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      #2;
      checkOutput("reset_rx_data", 32'(rx_data), 32'h000);
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_miso", 32'(MISO), 32'd0);
      checkOutput("reset_state", 32'(dut.r_state), 32'(IDLE));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] write address frame");
      applyStimulus(10'b00_1010_0101, 10);
      checkOutput("wa_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("wa_rx_data", 32'(rx_data), 32'h0A5);
      checkOutput("wa_miso", 32'(MISO), 32'd0);
      SS_n = 1'b1;
      tick();
      checkOutput("wa_rx_valid_one_cycle", 32'(rx_valid), 32'd0);
      checkOutput("wa_rx_data_hold", 32'(rx_data), 32'h0A5);
      checkOutput("wa_back_to_idle", 32'(dut.r_state), 32'(IDLE));

      $display("[TB] write data frame with spurious tx_valid");
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      applyStimulus(10'b01_0011_1100, 10);
      checkOutput("wd_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("wd_rx_data", 32'(rx_data), 32'h13C);
      checkOutput("wd_flag_unchanged", 32'(dut.r_rdAddrSeen), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("wd_spurious_miso", 32'(MISO), 32'd0);
      end
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      SS_n = 1'b1;
      tick();

      $display("[TB] reset mid-frame");
      applyStimulus(10'b10_1010_0101, 4);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_rx_data", 32'(rx_data), 32'h000);
      checkOutput("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_mid_miso", 32'(MISO), 32'd0);
      checkOutput("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
      tick();
      rst_n = 1'b1;
      SS_n  = 1'b1;
      tick();

      $display("[TB] read address frame");
      applyStimulus(10'h2A5, 10);
      checkOutput("ra_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("ra_rx_data", 32'(rx_data), 32'h2A5);
      checkOutput("ra_flag_set", 32'(dut.r_rdAddrSeen), 32'd1);
      SS_n = 1'b1;
      tick();
      checkOutput("ra_flag_survives_ss", 32'(dut.r_rdAddrSeen), 32'd1);

      $display("[TB] read data frame");
      applyStimulus(10'h300, 10);
      checkOutput("rd_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("rd_rx_data", 32'(rx_data), 32'h300);
      checkOutput("rd_flag_cleared", 32'(dut.r_rdAddrSeen), 32'd0);
      checkOutput("rd_state", 32'(dut.r_state), 32'(READ_DATA));
      tick();
      checkOutput("rd_miso_before_tx", 32'(MISO), 32'd0);
      tx_valid = 1'b1;
      tx_data  = 8'hC3;
      expByte  = 8'hC3;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      checkOutput("rd_miso_bit7", 32'(MISO), 32'(expByte[7]));
      for (int k = 6; k >= 0; k--) begin
         tick();
         checkOutput("rd_miso_bit", 32'(MISO), 32'(expByte[k]));
      end
      tick();
      checkOutput("rd_miso_after", 32'(MISO), 32'd0);
      tick();
      checkOutput("rd_miso_idle_hold", 32'(MISO), 32'd0);
      SS_n = 1'b1;
      tick();
      checkOutput("rd_back_to_idle", 32'(dut.r_state), 32'(IDLE));

      $display("[TB] aborted frame");
      applyStimulus(10'b00_1111_0000, 6);
      SS_n = 1'b1;
      tick();
      checkOutput("ab_state_idle", 32'(dut.r_state), 32'(IDLE));
      checkOutput("ab_no_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("ab_rx_data_hold", 32'(rx_data), 32'h300);
      checkOutput("ab_flag_unchanged", 32'(dut.r_rdAddrSeen), 32'd0);
      applyStimulus(10'b01_1100_0011, 10);
      checkOutput("ab_next_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("ab_next_rx_data", 32'(rx_data), 32'h1C3);
      SS_n = 1'b1;
      tick();
      checkOutput("ab_next_pulse_end", 32'(rx_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
